// File: rtl/i2s_in_receiver_if.sv
// rtl/i2s_in_receiver_if.sv - I2S input pins and PCM sample outputs of the receiver
interface i2s_in_receiver_if #(
  parameter int SAMPLE_BITS = 16
);
  logic                   i2s_sclk;
  logic                   i2s_ws;
  logic                   i2s_sdi;
  logic [SAMPLE_BITS-1:0] left_out;
  logic [SAMPLE_BITS-1:0] right_out;
  logic                   sample_valid;
  logic                   active;
  logic                   short_word;

  // master drives the I2S pins and consumes samples
  modport master (
    output i2s_sclk, i2s_ws, i2s_sdi,
    input  left_out, right_out, sample_valid, active, short_word
  );

  // slave is the receiver itself
  modport slave (
    input  i2s_sclk, i2s_ws, i2s_sdi,
    output left_out, right_out, sample_valid, active, short_word
  );
endinterface

// File: rtl/i2s_in_receiver.sv
// rtl/i2s_in_receiver.sv - I2S serial input to parallel L/R PCM samples in the core clock domain
module i2s_in_receiver #(
  parameter int SAMPLE_BITS = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic               clk,
  input  logic               reset,
  i2s_in_receiver_if.slave   bus
);
  localparam int CW = $clog2(SAMPLE_BITS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SB_W = CW'(SAMPLE_BITS);
  localparam logic [WW-1:0] TO_W = WW'(TIMEOUT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ws_sync_q, sdi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, ws_s, sdi_s;
  logic                   sclk_rise, ws_edge;

  logic [0:0]             state_q, state_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d, shift_n;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_n;
  logic                   ws_prev_q, ws_prev_d;
  // ws_prev is only meaningful once a bit clock edge has been seen since reset/timeout
  logic                   ws_seen_q, ws_seen_d;
  logic [SAMPLE_BITS-1:0] left_hold_q, left_hold_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   active_q, active_d;
  logic                   short_q, short_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic [SAMPLE_BITS-1:0] word;
  logic [CW-1:0]          pad;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ws_s      = ws_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ws_edge   = sclk_rise & ws_seen_q & (ws_s != ws_prev_q);

  // Synchronise the asynchronous I2S pins and remember the previous synced bit clock
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i2s_sclk};
      ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], bus.i2s_ws};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], bus.i2s_sdi};
      sclk_prev_q <= sclk_s;
    end
  end

  // Framing, word assembly, pair emission and loss-of-clock watchdog
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ws_prev_d   = ws_prev_q;
    ws_seen_d   = ws_seen_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    active_d    = active_q;
    short_d     = short_q;
    wd_d        = wd_q;

    // bits past SAMPLE_BITS are dropped; bit count saturates
    if (cnt_q < SB_W) begin
      shift_n = {shift_q[SAMPLE_BITS-2:0], sdi_s};
      cnt_n   = cnt_q + 1'b1;
    end else begin
      shift_n = shift_q;
      cnt_n   = cnt_q;
    end
    // left-align a short word, zero filling the LSBs
    pad  = SB_W - cnt_n;
    word = shift_n << pad;

    if (sclk_rise) begin
      wd_d      = '0;
      ws_prev_d = ws_s;
      ws_seen_d = 1'b1;
      if (state_q == IDLE) begin
        if (ws_edge) begin
          state_d = RUN;
          shift_d = '0;
          cnt_d   = '0;
        end
      end else if (ws_edge) begin
        // the bit on the ws transition is the LSB of the outgoing word
        shift_d  = '0;
        cnt_d    = '0;
        active_d = 1'b1;
        if (cnt_n < SB_W) short_d = 1'b1;
        if (ws_prev_q) begin
          right_d = word;
          left_d  = left_hold_q;
          valid_d = 1'b1;
        end else begin
          left_hold_d = word;
        end
      end else begin
        shift_d = shift_n;
        cnt_d   = cnt_n;
      end
    end else if (wd_q == TO_W) begin
      state_d   = IDLE;
      active_d  = 1'b0;
      ws_seen_d = 1'b0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ws_prev_q   <= 1'b0;
      ws_seen_q   <= 1'b0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      short_q     <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ws_prev_q   <= ws_prev_d;
      ws_seen_q   <= ws_seen_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      short_q     <= short_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.left_out     = left_q;
  assign bus.right_out    = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.active       = active_q;
  assign bus.short_word   = short_q;
endmodule

// File: tb/tb_i2s_in_receiver.sv
// tb/tb_i2s_in_receiver.sv - scoreboard bench for the I2S input receiver
module tb_i2s_in_receiver;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   pulses   = 0;
  int   p0;
  logic [31:0] sb[$];
  logic [31:0] exp_pair;

  always #10 clk = ~clk;

  i2s_in_receiver_if #(.SAMPLE_BITS(16)) bus ();

  i2s_in_receiver #(.SAMPLE_BITS(16), .SYNC_STAGES(2), .TIMEOUT(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r);
    sb.push_back({l, r});
  endtask

  // one bit clock period = 4 core clocks, data changes mid-low
  task automatic bit_out(input logic ws, input logic sd);
    bus.i2s_ws  = ws;
    bus.i2s_sdi = sd;
    #20 bus.i2s_sclk = 1'b1;
    #40 bus.i2s_sclk = 1'b0;
    #20;
  endtask

  // d is left-aligned; ws moves to the other channel on the last bit of the slot
  task automatic send_slot(input logic ch, input logic [31:0] d, input int nbits,
                           input int from, input int upto);
    for (int i = from; i < upto; i++)
      bit_out((i == nbits - 1) ? ~ch : ch, d[31-i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
    send_slot(1'b0, l, nbits, 0, nbits);
    send_slot(1'b1, r, nbits, 0, nbits);
  endtask

  // tail of a right word followed by the transition into a left word
  task automatic lead_in(input int n);
    repeat (n) bit_out(1'b1, 1'b1);
    bit_out(1'b0, 1'b0);
  endtask

  task automatic settle(input int n);
    #5;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #5;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // Monitor: every sample_valid pops the scoreboard
  always @(negedge clk) begin
    if (bus.sample_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got left=0x%0h right=0x%0h expected no pulse",
                 bus.left_out, bus.right_out);
      end else begin
        exp_pair = sb.pop_front();
        check("left_out", {16'h0, bus.left_out}, {16'h0, exp_pair[31:16]});
        check("right_out", {16'h0, bus.right_out}, {16'h0, exp_pair[15:0]});
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.i2s_sclk = 1'b0;
    bus.i2s_ws   = 1'b0;
    bus.i2s_sdi  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_left", {16'h0, bus.left_out}, 32'h0);
    check("rst_right", {16'h0, bus.right_out}, 32'h0);
    check("rst_valid", {31'h0, bus.sample_valid}, 32'h0);
    check("rst_active", {31'h0, bus.active}, 32'h0);
    check("rst_short", {31'h0, bus.short_word}, 32'h0);
    reset = 1'b0;

    // 1: 32-bit slots, 16 MSBs carry the sample
    lead_in(3);
    for (int f = 0; f < 3; f++) begin
      push_exp(16'h1234, 16'hABCD);
      send_frame(32'h1234_0000, 32'hABCD_0000, 32);
    end
    settle(8);
    check("t1_pulses", pulses, 3);
    check("t1_active", {31'h0, bus.active}, 32'h1);
    check("t1_short", {31'h0, bus.short_word}, 32'h0);

    // 2: stream joined mid-word
    pulse_reset();
    lead_in(7);
    p0 = pulses;
    send_slot(1'b0, 32'h1111_0000, 32, 0, 32);
    settle(8);
    check("t2_no_early_pulse", pulses, p0);
    push_exp(16'h1111, 16'h2222);
    send_slot(1'b1, 32'h2222_0000, 32, 0, 32);
    settle(8);
    check("t2_one_pulse", pulses, p0 + 1);

    // 6: 100 back-to-back frames
    p0 = pulses;
    for (int f = 0; f < 100; f++) begin
      push_exp(16'h8000, 16'h7FFF);
      send_frame(32'h8000_0000, 32'h7FFF_0000, 32);
    end
    settle(8);
    check("t6_pulses", pulses - p0, 100);
    check("t6_short", {31'h0, bus.short_word}, 32'h0);

    // 3: 12-bit slots then 16-bit slots
    push_exp(16'hABC0, 16'h1230);
    send_frame(32'hABC0_0000, 32'h1230_0000, 12);
    settle(8);
    check("t3_short_set", {31'h0, bus.short_word}, 32'h1);
    push_exp(16'h5555, 16'hAAAA);
    send_frame(32'h5555_0000, 32'hAAAA_0000, 16);
    settle(8);
    check("t3_short_sticky", {31'h0, bus.short_word}, 32'h1);

    // 4: bit clock stops
    settle(4000);
    check("t4_active_before_to", {31'h0, bus.active}, 32'h1);
    settle(1000);
    check("t4_active_after_to", {31'h0, bus.active}, 32'h0);
    check("t4_left_hold", {16'h0, bus.left_out}, 32'h5555);
    check("t4_right_hold", {16'h0, bus.right_out}, 32'hAAAA);
    lead_in(3);
    settle(8);
    check("t4_active_no_word", {31'h0, bus.active}, 32'h0);
    push_exp(16'h0F0F, 16'hF0F0);
    send_frame(32'h0F0F_0000, 32'hF0F0_0000, 32);
    settle(8);
    check("t4_active_again", {31'h0, bus.active}, 32'h1);

    // 5: reset mid right word
    send_slot(1'b0, 32'h7777_0000, 32, 0, 32);
    send_slot(1'b1, 32'h9999_0000, 32, 0, 10);
    pulse_reset();
    check("t5_left", {16'h0, bus.left_out}, 32'h0);
    check("t5_right", {16'h0, bus.right_out}, 32'h0);
    check("t5_valid", {31'h0, bus.sample_valid}, 32'h0);
    check("t5_active", {31'h0, bus.active}, 32'h0);
    check("t5_short", {31'h0, bus.short_word}, 32'h0);
    p0 = pulses;
    send_slot(1'b1, 32'h9999_0000, 32, 10, 32);
    settle(8);
    check("t5_no_broken_pulse", pulses, p0);
    push_exp(16'h4242, 16'h2424);
    send_frame(32'h4242_0000, 32'h2424_0000, 32);
    settle(8);
    check("t5_resume_pulse", pulses, p0 + 1);
    check("t5_active_resume", {31'h0, bus.active}, 32'h1);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
